obstacle_placer: RTL

OBSTACLE_PLACER -- requirements
Module: obstacle_placer

---
 rtl/obstacle_placer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_placer.sv
// Obstacle placer: on request, draws random candidate cells, screens them against the snake
// body, the head neighbourhood and existing obstacles, then commits one. Option: OBSTACLE_SPACING_EN.
module obstacle_placer #(
  parameter int GRID_W     = 14,
  parameter int GRID_H     = 10,
  parameter int MAX_LENGTH = 50,
  parameter int MAX_OBS    = 15,
  parameter int OBS_EVERY  = 4,
  parameter int MAX_TRIES  = 8
) (
  input  logic                             clk,
  input  logic                             s_reset,
  input  logic [MAX_LENGTH-1:0][7:0]       body,
  input  logic [7:0]                       curr_length,
  input  logic                             goodColl,
  input  logic                             obstacleFlag,
  input  logic [3:0]                       randX,
  input  logic [3:0]                       randY,
  input  logic [3:0]                       x,
  input  logic [3:0]                       y,
  output logic                             obstacle,
  output logic [$clog2(MAX_OBS+1)-1:0]     obstacleCount,
  output logic                             busy,
  output logic                             placed,
  output logic                             failed
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int CW    = $clog2(MAX_OBS + 1);
  localparam int TW    = $clog2(MAX_TRIES + 1);
  localparam int EW    = (OBS_EVERY > 1) ? $clog2(OBS_EVERY) : 1;
  localparam int IW    = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCAN, S_EVAL, S_COMMIT, S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [NCELL-1:0] occ_q, occ_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    evt_q, evt_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic             pending_q, pending_d;
  logic             flag_q, flag_d;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       idx_q, idx_d;
  logic             hit_q, hit_d;

  // Out-of-range coordinates (including 0 and neighbours past the edge) read as empty.
  function automatic logic cell_at(input logic [NCELL-1:0] occ, input int cx, input int cy);
    if (cx < 1 || cx > GRID_W || cy < 1 || cy > GRID_H) return 1'b0;
    return |(occ & ({{(NCELL-1){1'b0}}, 1'b1} << ((cx - 1) + (cy - 1) * GRID_W)));
  endfunction

  logic [3:0] cand_x, cand_y, head_x, head_y;
  logic [7:0] scan_len, seg;
  logic       last_seg, in_range, head_adj, occupied, reject;
  logic       len_ok, commit_ok, req;
  logic [8:0] len_lhs, len_rhs;

  assign cand_x = cand_q[7:4];
  assign cand_y = cand_q[3:0];
  assign head_x = body[0][7:4];
  assign head_y = body[0][3:0];
  assign seg    = body[idx_q[IW-1:0]];

  always_comb begin
    scan_len = (curr_length > 8'(MAX_LENGTH)) ? 8'(MAX_LENGTH) : curr_length;
    last_seg = (scan_len == 8'd0) || (idx_q == scan_len - 8'd1);
    in_range = (cand_x != 4'd0) && (int'(cand_x) <= GRID_W) &&
               (cand_y != 4'd0) && (int'(cand_y) <= GRID_H);
    head_adj = ((cand_x == head_x) &&
                (({1'b0, cand_y} == {1'b0, head_y} + 5'd1) ||
                 ({1'b0, head_y} == {1'b0, cand_y} + 5'd1))) ||
               ((cand_y == head_y) &&
                (({1'b0, cand_x} == {1'b0, head_x} + 5'd1) ||
                 ({1'b0, head_x} == {1'b0, cand_x} + 5'd1)));
    occupied = cell_at(occ_q, int'(cand_x), int'(cand_y));
`ifdef OBSTACLE_SPACING_EN
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        if (cell_at(occ_q, int'(cand_x) + int'(i) - 1, int'(cand_y) + int'(j) - 1))
          occupied = 1'b1;
      end
    end
`endif
    reject    = !in_range || hit_q || head_adj || occupied;
    len_lhs   = (9'(cnt_q) + 9'd1) << 1;
    len_rhs   = 9'(curr_length) + 9'd2;
    len_ok    = (curr_length < 8'd4) || (len_lhs < len_rhs);
    commit_ok = len_ok && (cnt_q != CW'(MAX_OBS));
    req       = ((obstacleFlag && !flag_q) ||
                 (goodColl && (evt_q == EW'(OBS_EVERY - 1)))) &&
                (cnt_q != CW'(MAX_OBS));
  end

  always_ff @(posedge clk) begin
    if (s_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pending_q) state_d = S_LOAD;
      S_LOAD:   state_d = S_SCAN;
      S_SCAN:   if (last_seg) state_d = S_EVAL;
      S_EVAL: begin
        if (!reject)                      state_d = S_COMMIT;
        else if (int'(tries_q) < MAX_TRIES) state_d = S_LOAD;
        else                              state_d = S_FAIL;
      end
      S_COMMIT: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (!obstacleFlag) state_d = S_IDLE;
  end

  // Pulses are suppressed when the cycle is being aborted by reset or mode-off.
  always_comb begin
    busy          = (state_q != S_IDLE) && !s_reset;
    placed        = (state_q == S_COMMIT) && commit_ok && obstacleFlag && !s_reset;
    failed        = (state_q == S_FAIL) && obstacleFlag && !s_reset;
    obstacleCount = s_reset ? '0 : cnt_q;
    obstacle      = cell_at(occ_q, int'(x), int'(y));
  end

  always_comb begin
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    evt_d     = evt_q;
    tries_d   = tries_q;
    pending_d = pending_q;
    flag_d    = obstacleFlag;
    cand_d    = cand_q;
    idx_d     = idx_q;
    hit_d     = hit_q;

    if (goodColl)
      evt_d = (evt_q == EW'(OBS_EVERY - 1)) ? '0 : evt_q + EW'(1);

    // A request arriving while one is still queued is dropped, not stacked.
    if (pending_q && state_q == S_IDLE) pending_d = 1'b0;
    else if (req)                       pending_d = 1'b1;

    case (state_q)
      S_IDLE: if (pending_q) tries_d = '0;
      S_LOAD: begin
        cand_d  = {randX, randY};
        idx_d   = '0;
        hit_d   = 1'b0;
        tries_d = tries_q + TW'(1);
      end
      S_SCAN: begin
        if (scan_len != 8'd0) hit_d = hit_q | (seg == cand_q);
        idx_d = idx_q + 8'd1;
      end
      S_COMMIT: begin
        if (commit_ok) begin
          occ_d = occ_q | ({{(NCELL-1){1'b0}}, 1'b1} <<
                           ((int'(cand_x) - 1) + (int'(cand_y) - 1) * GRID_W));
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (!obstacleFlag) begin
      occ_d     = '0;
      cnt_d     = '0;
      evt_d     = '0;
      tries_d   = '0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      occ_q     <= '0;
      cnt_q     <= '0;
      evt_q     <= '0;
      tries_q   <= '0;
      pending_q <= 1'b0;
      flag_q    <= 1'b0;
      cand_q    <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      evt_q     <= evt_d;
      tries_q   <= tries_d;
      pending_q <= pending_d;
      flag_q    <= flag_d;
      cand_q    <= cand_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
    end
  end

endmodule
